// File: rtl/cla_subtractor_seq.sv
// Word-serial subtractor: diff = a - b - bin computed one nibble per clock
// through a single 4-bit carry-lookahead slice using a + ~b + ~bin.
module cla_subtractor_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] nb_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_sign;
  logic             b_sign;

  logic [3:0]       an, bn, g, p, s;
  logic [4:0]       c;
  logic [WIDTH-1:0] diff_nx;

  always_comb begin
    an = '0;
    bn = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        an = a_r[4*i +: 4];
        bn = nb_r[4*i +: 4];
      end
    end
    g    = an & bn;
    p    = an ^ bn;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | ((&p) & c[0]);
    s    = p ^ c[3:0];
    // Full next-diff word so zero/ovf can be registered on the same edge as the last nibble
    diff_nx = diff;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt == CW'(i)) diff_nx[4*i +: 4] = s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      nb_r      <= '0;
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            nb_r     <= ~b;
            carry    <= ~bin;
            a_sign   <= a[WIDTH-1];
            b_sign   <= b[WIDTH-1];
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff  <= diff_nx;
          carry <= c[4];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            bout      <= ~c[4];
            zero      <= (diff_nx == '0);
            ovf       <= (a_sign != b_sign) & (diff_nx[WIDTH-1] != a_sign);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_subtractor_seq.sv
// Self-checking bench for cla_subtractor_seq (WIDTH=16): directed vectors,
// randomized operands against an integer-arithmetic model, backpressure, reset.
module tb_cla_subtractor_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cla_subtractor_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  // Reference: plain integer arithmetic, unsigned for diff/borrow, signed range for overflow
  function automatic logic [18:0] model(input logic [15:0] va, input logic [15:0] vb,
                                        input logic vbin);
    int ur;
    int sr;
    logic [15:0] d;
    logic bo, z, ov;
    ur = int'(va) - int'(vb) - int'(vbin);
    sr = int'($signed(va)) - int'($signed(vb)) - int'(vbin);
    d  = 16'(ur);
    bo = (ur < 0);
    z  = (d == 16'h0);
    ov = (sr > 32767) || (sr < -32768);
    return {d, bo, z, ov};
  endfunction

  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                      output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        a = va; b = vb; bin = vbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b1;
      end
    end
  endtask

  task automatic collect(output bit got, output int lat, output logic [18:0] res);
    got = 1'b0; lat = 0; res = '0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1; lat = k; res = {diff, bout, zero, ovf};
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'hABCD; b = 16'h1234; bin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({in_ready, out_valid, diff, bout, zero, ovf} !== {1'b1, 1'b0, 16'h0, 3'b000})
      $display("FAIL reset_state: got rdy=%b vld=%b diff=%h flags=%b%b%b required rdy=1 vld=0 diff=0000 flags=000",
               in_ready, out_valid, diff, bout, zero, ovf);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_priority: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    bit ok, got;
    int lat;
    logic [18:0] res;
    out_ready = 1'b1;
    send(16'h1234, 16'h0034, 1'b0, ok);
    collect(got, lat, res);
    total_cnt++;
    if (!ok || !got || lat != 4)
      $display("FAIL basic_latency: got accepted=%b valid=%b latency=%0d required 1 1 4", ok, got, lat);
    else pass_cnt++;
    total_cnt++;
    if (res !== {16'h1200, 3'b000})
      $display("FAIL basic_result: got %h required %h", res, {16'h1200, 3'b000});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL basic_return_idle: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_vectors;
    logic [32:0] vec [6];
    logic [32:0] v;
    logic [18:0] exp, res;
    bit ok, got;
    int lat;
    vec[0] = {16'h0000, 16'h0001, 1'b0};
    vec[1] = {16'h8000, 16'h0001, 1'b0};
    vec[2] = {16'h7FFF, 16'hFFFF, 1'b0};
    vec[3] = {16'h5555, 16'h5554, 1'b1};
    vec[4] = {16'h0000, 16'h0000, 1'b1};
    vec[5] = {16'hFFFF, 16'hFFFF, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 46; i++) begin
      if (i < 6) v = vec[i];
      else begin
        v = {16'($urandom), 16'($urandom), 1'($urandom)};
        if ($urandom_range(0, 3) == 0) v[16:1] = v[32:17];
      end
      exp = model(v[32:17], v[16:1], v[0]);
      send(v[32:17], v[16:1], v[0], ok);
      collect(got, lat, res);
      total_cnt++;
      if (!ok || !got || lat != 4 || res !== exp)
        $display("FAIL vector_%0d a=%h b=%h bin=%b: got acc=%b vld=%b lat=%0d res=%h required lat=4 res=%h",
                 i, v[32:17], v[16:1], v[0], ok, got, lat, res, exp);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    bit ok, got;
    int lat;
    logic [18:0] res1, res2, exp1, exp2;
    exp1 = model(16'hC3A5, 16'h1F0E, 1'b1);
    exp2 = model(16'h0F00, 16'h0F01, 1'b0);
    out_ready = 1'b0;
    send(16'hC3A5, 16'h1F0E, 1'b1, ok);
    collect(got, lat, res1);
    total_cnt++;
    if (!ok || !got || res1 !== exp1)
      $display("FAIL bp_first_result: got vld=%b res=%h required res=%h", got, res1, exp1);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
      total_cnt++;
      if ({out_valid, in_ready, diff, bout, zero, ovf} !== {2'b10, exp1})
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b res=%h required vld=1 rdy=0 res=%h",
                 i, out_valid, in_ready, {diff, bout, zero, ovf}, exp1);
      else pass_cnt++;
    end
    @(negedge clk);
    a = 16'h0F00; b = 16'h0F01; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_handshake: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL bp_second_accept: got rdy=%b required 0", in_ready);
    else pass_cnt++;
    collect(got, lat, res2);
    total_cnt++;
    if (!got || lat != 4 || res2 !== exp2)
      $display("FAIL bp_second_result: got vld=%b lat=%0d res=%h required lat=4 res=%h", got, lat, res2, exp2);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    bit ok, got;
    int lat, pulses;
    logic [18:0] res;
    out_ready = 1'b1;
    send(16'h1234, 16'h0001, 1'b0, ok);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (!ok || {in_ready, out_valid, diff, bout, zero, ovf} !== {1'b1, 1'b0, 16'h0, 3'b000})
      $display("FAIL abort_state: got acc=%b rdy=%b vld=%b diff=%h required rdy=1 vld=0 diff=0000",
               ok, in_ready, out_valid, diff);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    total_cnt++;
    if (pulses != 0)
      $display("FAIL abort_no_pulse: got %0d out_valid cycles required 0", pulses);
    else pass_cnt++;
    send(16'h00FF, 16'h0F0F, 1'b0, ok);
    collect(got, lat, res);
    total_cnt++;
    if (!ok || !got || lat != 4 || res !== model(16'h00FF, 16'h0F0F, 1'b0))
      $display("FAIL abort_recover: got vld=%b lat=%0d res=%h required res=%h",
               got, lat, res, model(16'h00FF, 16'h0F0F, 1'b0));
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
